// File: rtl/vector_register_file.sv
// Parametrised vector register file: NUM_REGS x DATA_W, one write port, two registered read
// ports with write bypass, per-register valid bits and a clear sweep. Optional: VRF_BYTE_MASK_EN.
module vector_register_file #(
    parameter int unsigned DATA_W   = 512,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
`ifdef VRF_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0]           wr_be,
`endif
    input  logic                          rd_en1,
    input  logic [$clog2(NUM_REGS)-1:0]   rd_addr1,
    input  logic                          rd_en2,
    input  logic [$clog2(NUM_REGS)-1:0]   rd_addr2,
    input  logic                          clr_start,
    output logic [DATA_W-1:0]             rd_data1,
    output logic                          rd_valid1,
    output logic [DATA_W-1:0]             rd_data2,
    output logic                          rd_valid2,
    output logic [NUM_REGS-1:0]           reg_valid,
    output logic                          busy,
    output logic                          clr_done,
    output logic                          err_addr,
    output logic                          wr_drop
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic                wr_in_range_c, rd1_in_range_c, rd2_in_range_c;
    logic                wr_ok_c, wr_set_c;
    logic [ADDR_W-1:0]   wr_idx_c, rd1_idx_c, rd2_idx_c;
    logic [DATA_W-1:0]   wr_word_c, rd_word1_c, rd_word2_c;

    // Address checks, write-word merge and bypassed read values
    always_comb begin
        wr_in_range_c  = 32'(wr_addr)  < NUM_REGS;
        rd1_in_range_c = 32'(rd_addr1) < NUM_REGS;
        rd2_in_range_c = 32'(rd_addr2) < NUM_REGS;
        wr_idx_c       = wr_in_range_c  ? wr_addr  : '0;
        rd1_idx_c      = rd1_in_range_c ? rd_addr1 : '0;
        rd2_idx_c      = rd2_in_range_c ? rd_addr2 : '0;
        wr_ok_c        = wr_en && !busy && wr_in_range_c;
`ifdef VRF_BYTE_MASK_EN
        wr_word_c      = regs[wr_idx_c];
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (wr_be[b]) wr_word_c[b*8 +: 8] = wr_data[b*8 +: 8];
        end
        wr_set_c       = |wr_be;
`else
        wr_word_c      = wr_data;
        wr_set_c       = 1'b1;
`endif
        rd_word1_c = '0;
        if (rd1_in_range_c)
            rd_word1_c = (wr_ok_c && wr_addr == rd_addr1) ? wr_word_c : regs[rd1_idx_c];
        rd_word2_c = '0;
        if (rd2_in_range_c)
            rd_word2_c = (wr_ok_c && wr_addr == rd_addr2) ? wr_word_c : regs[rd2_idx_c];
    end

    // Storage, read ports, status pulses and clear-sweep FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_valid <= '0;
            rd_data1  <= '0;
            rd_data2  <= '0;
            rd_valid1 <= 1'b0;
            rd_valid2 <= 1'b0;
            busy      <= 1'b0;
            clr_done  <= 1'b0;
            err_addr  <= 1'b0;
            wr_drop   <= 1'b0;
            state     <= IDLE;
            idx       <= '0;
        end else begin
            rd_valid1 <= rd_en1;
            rd_valid2 <= rd_en2;
            if (rd_en1) rd_data1 <= rd_word1_c;
            if (rd_en2) rd_data2 <= rd_word2_c;
            err_addr  <= (wr_en && !wr_in_range_c) || (rd_en1 && !rd1_in_range_c)
                         || (rd_en2 && !rd2_in_range_c);
            wr_drop   <= wr_en && busy;
            clr_done  <= 1'b0;

            if (wr_ok_c) begin
                regs[wr_idx_c] <= wr_word_c;
                if (wr_set_c) reg_valid[wr_idx_c] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                CLEAR: begin
                    // No write can coincide here: writes are rejected while busy
                    regs[idx]      <= '0;
                    reg_valid[idx] <= 1'b0;
                    if (idx == ADDR_W'(NUM_REGS - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                        idx      <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
